// File: rtl/gate_arbiter.sv
// gate_arbiter: round-robin sequencer that time-shares one external two-input
// gate cell among N requesters. The grant latches the requester's operands onto
// gate_A/gate_B. After SETTLE wait cycles, gate_C is captured into Y, and the
// requester receives a one-cycle ack.
module gate_arbiter #(
  parameter int N      = 4,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] gnt,
  output logic [N-1:0] ack,
  output logic         Y,
  output logic         busy,
  output logic         gate_A,
  output logic         gate_B,
  input  logic         gate_C
);

  localparam int          CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int          PW = (N < 2) ? 1 : $clog2(N);
  localparam int unsigned NU = N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]   gnt_d, ack_d;
  logic           y_d, busy_d, ga_d, gb_d;

  logic           sel_valid;
  logic [PW-1:0]  sel_idx;
  logic [PW-1:0]  pos;

  // Round-robin pick: first requester at or above ptr, wrapping past N-1.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    pos       = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      pos = PW'((32'(ptr_q) + k) % NU);
      if (!sel_valid && req[pos]) begin
        sel_valid = 1'b1;
        sel_idx   = pos;
      end
    end
  end

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt;
    ack_d   = '0;
    y_d     = Y;
    ga_d    = gate_A;
    gb_d    = gate_B;
    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          gnt_d   = N'(1) << sel_idx;
          ga_d    = A[sel_idx];
          gb_d    = B[sel_idx];
          cnt_d   = CW'(SETTLE);
          ptr_d   = (sel_idx == PW'(N - 1)) ? '0 : sel_idx + 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          y_d     = gate_C;
          ack_d   = gnt;
          state_d = DONE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // busy is registered, so it follows the state being entered
    busy_d = (state_d != IDLE);
  end

  // State and output registers; asynchronous reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt     <= '0;
      ack     <= '0;
      Y       <= 1'b0;
      busy    <= 1'b0;
      gate_A  <= 1'b0;
      gate_B  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt     <= gnt_d;
      ack     <= ack_d;
      Y       <= y_d;
      busy    <= busy_d;
      gate_A  <= ga_d;
      gate_B  <= gb_d;
    end
  end

endmodule

// File: tb/tb_gate_arbiter.sv
// Testbench for gate_arbiter (N=4, SETTLE=2) with an OR cell on the shared port.
module tb_gate_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, A, B;
  logic [3:0] gnt, ack;
  logic       Y, busy, gate_A, gate_B, gate_C;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int m_ptr  = 0;

  gate_arbiter #(.N(4), .SETTLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .A(A), .B(B),
    .gnt(gnt), .ack(ack), .Y(Y), .busy(busy),
    .gate_A(gate_A), .gate_B(gate_B), .gate_C(gate_C)
  );

  assign gate_C = gate_A | gate_B;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Reference rule: first set request bit searching upward from p, wrapping.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Waits (bounded) for a grant and then its ack; reports what was observed.
  // With mid set, the granted requester's A is forced high, B scrambled and
  // its req dropped while the transaction is in flight.
  task automatic observe(input bit mid, output logic [3:0] g, output logic [3:0] a,
                         output logic y, output int gw, output int lat,
                         output int gc, output bit ag, output logic ga, output logic gb);
    g = 'x; a = 'x; y = 1'bx; gw = -1; lat = -1; gc = -1; ag = 1'b0; ga = 1'bx; gb = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (gnt !== 4'b0000) begin gw = i; break; end
    end
    if (gw < 0) return;
    g = gnt; gc = cyc;
    if (mid) begin
      A   = A | g;
      B   = 4'($urandom);
      req = req & ~g;
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack !== 4'b0000) begin lat = i; break; end
    end
    if (lat < 0) return;
    a = ack; y = Y; ga = gate_A; gb = gate_B;
    ag = ((ack & ~gnt) == 4'b0000) && (gnt === g) && (busy === 1'b1);
  endtask

  task automatic test_reset();
    logic [3:0] g, a; logic y, ga, gb; int gw, lat, gc; bit ag;
    rst_n = 1'b0; req = 4'b1111; A = 4'b1111; B = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({gnt, ack} !== 8'h00) $display("FAIL reset_gnt_ack: got %b_%b want 0000_0000", gnt, ack); else passed++;
    total++; if ({Y, busy, gate_A, gate_B} !== 4'b0000) $display("FAIL reset_outs: got Y/busy/gA/gB=%b want 0000", {Y, busy, gate_A, gate_B}); else passed++;
    @(negedge clk) rst_n = 1'b1;
    m_ptr = 0;
    observe(1'b0, g, a, y, gw, lat, gc, ag, ga, gb);
    total++; if (g !== 4'b0001 || gw !== 1) $display("FAIL reset_first_grant: got gnt=%b after %0d edges want 0001 after 1", g, gw); else passed++;
    total++; if (y !== 1'b1 || a !== 4'b0001) $display("FAIL reset_first_ack: got Y=%b ack=%b want 1 0001", y, a); else passed++;
    m_ptr = 1;
    req = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [3:0] g, a; logic y, ga, gb; int gw, lat, gc; bit ag;
    req = 4'b0100; A = 4'b0100; B = 4'b0000;
    observe(1'b0, g, a, y, gw, lat, gc, ag, ga, gb);
    total++; if (g !== 4'b0100 || gw !== 1) $display("FAIL single_gnt: got %b after %0d edges want 0100 after 1", g, gw); else passed++;
    total++; if (lat !== 3) $display("FAIL single_latency: got %0d want 3", lat); else passed++;
    total++; if (a !== 4'b0100 || y !== 1'b1) $display("FAIL single_ack: got ack=%b Y=%b want 0100 1", a, y); else passed++;
    total++; if (ga !== 1'b1 || gb !== 1'b0 || ag !== 1'b1) $display("FAIL single_hold: got gA=%b gB=%b ackgnt=%b want 1 0 1", ga, gb, ag); else passed++;
    m_ptr = 3;
    req = 4'b0000;
    @(posedge clk); #1;
    total++; if ({gnt, ack, busy} !== 9'b0) $display("FAIL single_idle: got gnt=%b ack=%b busy=%b want 0000 0000 0", gnt, ack, busy); else passed++;
    total++; if (Y !== 1'b1) $display("FAIL single_y_hold: got %b want 1", Y); else passed++;
  endtask

  task automatic test_truth_table();
    logic [3:0] g, a; logic y, ga, gb; int gw, lat, gc; bit ag;
    for (int ab = 0; ab < 4; ab++) begin
      req = 4'b0010;
      A = {2'b00, ab[1], 1'b0};
      B = {2'b00, ab[0], 1'b0};
      observe(1'b0, g, a, y, gw, lat, gc, ag, ga, gb);
      total++;
      if (g !== 4'b0010 || a !== 4'b0010 || y !== (ab[1] | ab[0]))
        $display("FAIL truth_%0d: got gnt=%b ack=%b Y=%b want 0010 0010 %b", ab, g, a, y, ab[1] | ab[0]);
      else passed++;
      req = 4'b0000;
      @(posedge clk); #1;
    end
    m_ptr = 2;
  endtask

  task automatic test_round_robin();
    logic [3:0] g, a; logic y, ga, gb; int gw, lat, gc, prev, e; bit ag;
    logic [3:0] as, bs;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    m_ptr = 0;
    req = 4'b1111; A = 4'($urandom); B = 4'($urandom);
    as = A; bs = B; prev = -1;
    for (int n = 0; n < 5; n++) begin
      e = pick(req, m_ptr);
      observe(1'b0, g, a, y, gw, lat, gc, ag, ga, gb);
      total++;
      if (g !== 4'(1 << e) || a !== g || y !== (as[e] | bs[e]))
        $display("FAIL rr_order_%0d: got gnt=%b ack=%b Y=%b want gnt=%b Y=%b", n, g, a, y, 4'(1 << e), as[e] | bs[e]);
      else passed++;
      if (n > 0) begin
        total++; if (gc - prev !== 5) $display("FAIL rr_spacing_%0d: got %0d cycles want 5", n, gc - prev); else passed++;
      end
      prev = gc; m_ptr = (e + 1) % 4;
    end
    req = 4'b0100;
    observe(1'b0, g, a, y, gw, lat, gc, ag, ga, gb);
    total++; if (g !== 4'b0100) $display("FAIL rr_setup: got %b want 0100", g); else passed++;
    m_ptr = 3;
    req = 4'b1001;
    for (int n = 0; n < 2; n++) begin
      e = pick(req, m_ptr);
      observe(1'b0, g, a, y, gw, lat, gc, ag, ga, gb);
      total++; if (g !== 4'(1 << e)) $display("FAIL rr_wrap_%0d: got %b want %b", n, g, 4'(1 << e)); else passed++;
      m_ptr = (e + 1) % 4;
    end
    req = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_midflight();
    logic [3:0] g, a; logic y, ga, gb; int gw, lat, gc; bit ag;
    req = 4'b0001; A = 4'b0000; B = 4'b0000;
    observe(1'b1, g, a, y, gw, lat, gc, ag, ga, gb);
    total++; if (a !== 4'b0001 || y !== 1'b0 || ag !== 1'b1) $display("FAIL midflight: got ack=%b Y=%b ackgnt=%b want 0001 0 1", a, y, ag); else passed++;
    m_ptr = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    logic [3:0] g, a; logic y, ga, gb; int gw, lat, gc; bit ag, seen;
    logic [3:0] as, bs;
    req = 4'b0001; A = 4'($urandom); B = 4'($urandom);
    gw = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (gnt !== 4'b0000) begin gw = i; break; end
    end
    total++; if (gnt !== 4'b0001) $display("FAIL rstwait_grant: got %b want 0001", gnt); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if ({gnt, ack, busy} !== 9'b0) $display("FAIL rstwait_abort: got gnt=%b ack=%b busy=%b want 0000 0000 0", gnt, ack, busy); else passed++;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (ack !== 4'b0000) seen = 1'b1; end
    total++; if (seen !== 1'b0) $display("FAIL rstwait_no_ack: got ack pulse=1 want 0"); else passed++;
    @(negedge clk) rst_n = 1'b1;
    m_ptr = 0;
    req = 4'b0011; as = A; bs = B;
    observe(1'b0, g, a, y, gw, lat, gc, ag, ga, gb);
    total++; if (g !== 4'b0001 || y !== (as[0] | bs[0])) $display("FAIL rstwait_regrant: got gnt=%b Y=%b want 0001 %b", g, y, as[0] | bs[0]); else passed++;
    m_ptr = 1;
    req = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [3:0] g, a; logic y, ga, gb; int gw, lat, gc, e; bit ag, mid;
    logic [3:0] as, bs;
    int bad = 0;
    req = 4'b0000;
    for (int n = 0; n < 40; n++) begin
      if (req == 4'b0000) req = 4'($urandom_range(1, 15));
      else req = req | 4'($urandom);
      A = 4'($urandom); B = 4'($urandom);
      as = A; bs = B;
      e = pick(req, m_ptr);
      mid = 1'($urandom_range(0, 1));
      observe(mid, g, a, y, gw, lat, gc, ag, ga, gb);
      total++;
      if (g !== 4'(1 << e) || gw !== 1 || lat !== 3 || a !== g || ag !== 1'b1 || y !== (as[e] | bs[e]))
        $display("FAIL random_%0d: got gnt=%b gw=%0d lat=%0d ack=%b Y=%b want gnt=%b gw=1 lat=3 Y=%b",
                 n, g, gw, lat, a, y, 4'(1 << e), as[e] | bs[e]);
      else passed++;
      m_ptr = (e + 1) % 4;
      if (!mid && $urandom_range(0, 1) == 1) req = req & ~4'(1 << e);
      @(posedge clk); #1;
      if (ack !== 4'b0000 || gnt !== 4'b0000) bad++;
    end
    total++; if (bad !== 0) $display("FAIL random_done_clear: got %0d non-idle DONE edges want 0", bad); else passed++;
    req = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; A = '0; B = '0;
    test_reset();
    test_single();
    test_truth_table();
    test_round_robin();
    test_midflight();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
